muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit owning the HI/LO register pair.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU/DIV/DIVU run over WIDTH cycles (start/busy/done handshake);
// MTHI/MTLO write HI/LO in a single cycle from IDLE.
// Optional feature macro: MULDIV_FAST_MULT_EN -- multiplies are computed
// combinationally at accept and go straight to the FIX state.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             stall,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI_OUT,
  output logic [WIDTH-1:0] LO_OUT
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_div_zero;

  logic               w_signed, w_b_zero, w_is_md;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  // Operand decode: signed ops use magnitudes, unsigned ops use raw values
  assign w_is_md  = ~op[2];
  assign w_signed = ~op[0];
  assign w_b_zero = (B == '0);
  assign w_mag_a  = (w_signed && A[WIDTH-1]) ? WIDTH'(-A) : A;
  assign w_mag_b  = (w_signed && B[WIDTH-1]) ? WIDTH'(-B) : B;

  // Shift-add step: add multiplicand to upper half when LSB of multiplier is set
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: {remainder, dividend} shifts left one bit per step
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_ge};

  // Sign correction applied in FIX
  always_comb begin
    w_prod   = r_neg_q ? (2*WIDTH)'(-r_acc) : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_res_lo = r_neg_q ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_res_hi = r_neg_r ? WIDTH'(-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic; stall holds the current state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!stall && start && w_is_md) begin
          if (op[1] && w_b_zero) begin
            w_next = S_FIX;
          end else begin
`ifdef MULDIV_FAST_MULT_EN
            w_next = op[1] ? S_RUN : S_FIX;
`else
            w_next = S_RUN;
`endif
          end
        end
      end
      S_RUN:   if (!stall && r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   if (!stall) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath, HI/LO and done/div_zero; everything frozen while stall is high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (!stall) begin
      r_done     <= (r_state == S_FIX);
      r_div_zero <= (r_state == S_FIX) && r_dz;
      case (r_state)
        S_IDLE: begin
          if (start && w_is_md) begin
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_is_div <= op[1];
            r_cnt    <= '0;
            r_dz     <= op[1] && w_b_zero;
            r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]) && !(op[1] && w_b_zero);
            r_neg_r  <= w_signed && A[WIDTH-1] && !(op[1] && w_b_zero);
            if (op[1]) begin
              // Divide-by-zero preloads the final HI=A / LO=all-ones result
              r_acc <= w_b_zero ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_mag_a};
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              r_acc <= {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`else
              r_acc <= {{WIDTH{1'b0}}, w_mag_b};
`endif
            end
          end else if (start && op == 3'd4) begin
            r_hi <= A;
          end else if (start && op == 3'd5) begin
            r_lo <= A;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign HI_OUT   = r_hi;
  assign LO_OUT   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, default build).
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stall = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI_OUT, LO_OUT;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .stall(stall), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .done(done), .div_zero(div_zero),
    .HI_OUT(HI_OUT), .LO_OUT(LO_OUT)
  );

  initial forever #5 CLK = ~CLK;

  // Edge counter used to time done pulses
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected result; lat = edges from accept until done is visible
  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge CLK);
    start = 1'b0; op = 3'd7; A = $urandom; B = $urandom;
  endtask

  task automatic wait_sb_empty(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops one expectation per new done pulse (held done under stall counts once)
  task automatic monitor_loop();
    logic prev_done = 1'b0;
    logic st;
    exp_t e;
    forever begin
      @(posedge CLK);
      st = stall;
      #1;
      if (done && !(prev_done && st)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hi", 64'(HI_OUT), 64'(e.hi));
          chk("lo", 64'(LO_OUT), 64'(e.lo));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
        end
      end
      prev_done = done;
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(HI_OUT), 64'd0);
    chk("rst_lo", 64'(LO_OUT), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // MULTU max*max, with an ignored MTLO start while busy
    push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    if (MUL_LAT > 1) begin
      chk("multu_busy", 64'(busy), 64'd1);
      start = 1'b1; op = 3'd5; A = 32'h5555_5555;
      @(negedge CLK);
      start = 1'b0;
      chk("run_hi_hold", 64'(HI_OUT), 64'd0);
      chk("run_lo_hold", 64'(LO_OUT), 64'd0);
    end
    wait_sb_empty("multu");

    // Signed divide: truncation toward zero, then MIN / -1 wrap
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_sb_empty("div_neg");
    push(32'h0000_0000, 32'h8000_0000, 1'b0, 33);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_sb_empty("div_min");

    // DIVU by zero: short latency, div_zero then clears
    push(32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1);
    issue(3'd3, 32'h0000_0005, 32'h0000_0000);
    wait_sb_empty("divu_zero");
    @(negedge CLK);
    chk("dz_clear", 64'(div_zero), 64'd0);
    chk("done_clear", 64'(done), 64'd0);

    // MULT -3*4 with 5 stalled cycles in RUN and start pulses while busy
    push(32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, MUL_LAT + 5);
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0004);
    if (MUL_LAT > 1) begin
      for (int i = 0; i < 10; i++) begin
        start = i[0]; op = 3'd0; A = 32'd1; B = 32'd1;
        @(negedge CLK);
      end
      start = 1'b0;
      stall = 1'b1;
      repeat (5) @(negedge CLK);
      stall = 1'b0;
    end
    wait_sb_empty("mult_stall");

    // DIVU 100/7 with stall raised while done is high: pulse is held
    push(32'h0000_0002, 32'h0000_000E, 1'b0, 33);
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 60 && !done; i++) @(negedge CLK);
    stall = 1'b1;
    repeat (3) @(negedge CLK);
    chk("done_held", 64'(done), 64'd1);
    stall = 1'b0;
    @(negedge CLK);
    chk("done_released", 64'(done), 64'd0);
    chk("divu_lo_kept", 64'(LO_OUT), 64'h0000_000E);
    wait_sb_empty("divu_stall");

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd4; A = 32'h1234_5678;
    @(negedge CLK);
    chk("mthi_busy", 64'(busy), 64'd0);
    op = 3'd5; A = 32'h0000_0009;
    @(negedge CLK);
    start = 1'b0; op = 3'd7;
    chk("mthi_hi", 64'(HI_OUT), 64'h1234_5678);
    chk("mtlo_lo", 64'(LO_OUT), 64'h0000_0009);
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);

    // Start under stall in IDLE and op 6 are both ignored
    stall = 1'b1; start = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF;
    @(negedge CLK);
    stall = 1'b0; op = 3'd6; B = 32'd3;
    @(negedge CLK);
    start = 1'b0; op = 3'd7;
    @(negedge CLK);
    chk("stall_idle_lo", 64'(LO_OUT), 64'h0000_0009);
    chk("noop_busy", 64'(busy), 64'd0);
    chk("noop_hi", 64'(HI_OUT), 64'h1234_5678);

    // Reset mid-DIVU aborts with no done pulse
    issue(3'd3, 32'hFFFF_0000, 32'd3);
    repeat (9) @(negedge CLK);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(HI_OUT), 64'd0);
    chk("abort_lo", 64'(LO_OUT), 64'd0);
    repeat (40) @(negedge CLK);
    chk("abort_no_done", 64'(done), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
